// File: rtl/tile_layer_gen.sv
// rtl/tile_layer_gen.sv - scrolling tile-layer renderer with shared tilemap RAM
//
// Purpose: fetches one 8-pixel tile per cell ahead of the beam. The tilemap is read
// first, then the planar graphics come from an external memory over a req/ack
// handshake, and the result is double-buffered into per-plane shift registers.
// The CPU shares the single map port and is stalled with counted wait states.
//
// Ports:
//   master_clk, RESET_N         clock, synchronous active-low reset
//   pixel_ce                    one-cycle pixel enable
//   HPIXSCRL, VPIXSCRL          scrolled beam position {cell, pixel-in-cell}
//   SCREEN_FLIP                 1 = emit LSB first and shift right
//   cpu_cs/we/addr/din/dout     CPU byte access to the map, cpu_wait stalls it
//   rom_req/addr/ack/data       graphics fetch handshake, plane p in data[8p+7:8p]
//   pixel_out, pixel_opaque     {colour, plane bits} and "any plane set"
//   underrun                    sticky: a tile boundary found no fetched data
module tile_layer_gen #(
  parameter int PLANES        = 4,
  parameter int COLOR_BITS    = 4,
  parameter int CODE_BITS     = 12,
  parameter int MAP_COLS_LOG2 = 6,
  parameter int MAP_ROWS_LOG2 = 5,
  parameter int ROM_AW        = 17,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                             master_clk,
  input  logic                             RESET_N,
  input  logic                             pixel_ce,
  input  logic [MAP_COLS_LOG2+2:0]         HPIXSCRL,
  input  logic [MAP_ROWS_LOG2+2:0]         VPIXSCRL,
  input  logic                             SCREEN_FLIP,
  input  logic                             cpu_cs,
  input  logic                             cpu_we,
  input  logic [MAP_COLS_LOG2+MAP_ROWS_LOG2:0] cpu_addr,
  input  logic [7:0]                       cpu_din,
  output logic [7:0]                       cpu_dout,
  output logic                             cpu_wait,
  output logic                             rom_req,
  output logic [ROM_AW-1:0]                rom_addr,
  input  logic                             rom_ack,
  input  logic [8*PLANES-1:0]              rom_data,
  output logic [COLOR_BITS+PLANES-1:0]     pixel_out,
  output logic                             pixel_opaque,
  output logic                             underrun
);

  localparam int MAP_AW = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
  localparam int HW     = MAP_COLS_LOG2 + 3;
  localparam int VW     = MAP_ROWS_LOG2 + 3;
  localparam int CCW    = COLOR_BITS + CODE_BITS;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, MAP_RD, MAP_DAT, ROM_REQ} fetch_state_t;

  fetch_state_t state, state_next;

  logic [7:0] map_lo [0:(1<<MAP_AW)-1];
  logic [7:0] map_hi [0:(1<<MAP_AW)-1];

  logic [MAP_AW-1:0]        port_addr;
  logic [15:0]              port_word;
  logic [CCW-1:0]           map_q;
  logic [MAP_AW-1:0]        fetch_cell;
  logic [2:0]               fetch_row;
  logic [COLOR_BITS-1:0]    fetch_color;
  logic [MAP_COLS_LOG2-1:0] next_col;

  logic [8*PLANES-1:0]      hold_planes, shift_reg, src_planes, shifted;
  logic [COLOR_BITS-1:0]    hold_color, color_lat, src_color;
  logic                     hold_valid;
  logic [PLANES-1:0]        pix_bits;

  logic                     cpu_active, cpu_done, cpu_grant, cpu_fin;
  logic [7:0]               wait_cnt;

  logic fetch_start, boundary, rom_take;

  assign fetch_start = pixel_ce && (HPIXSCRL[2:0] == 3'd0) && (state == IDLE);
  assign boundary    = pixel_ce && (HPIXSCRL[2:0] == 3'd7);
  assign rom_take    = (state == ROM_REQ) && rom_ack;
  assign next_col    = HPIXSCRL[HW-1:3] + MAP_COLS_LOG2'(1);

  // The fetcher owns the map port only in MAP_RD; every other cycle is the CPU's.
  assign cpu_grant = cpu_cs && !cpu_done && !cpu_active && (state != MAP_RD);
  assign cpu_fin   = cpu_active && (wait_cnt == WAIT_LAST);
  assign cpu_wait  = cpu_cs && !cpu_fin;

  assign port_addr = (state == MAP_RD) ? fetch_cell : cpu_addr[MAP_AW-1:0];
  assign port_word = {map_hi[port_addr], map_lo[port_addr]};

  always_ff @(posedge master_clk) begin
    if (cpu_grant && cpu_we) begin
      if (cpu_addr[MAP_AW]) map_hi[port_addr] <= cpu_din;
      else                  map_lo[port_addr] <= cpu_din;
    end
    if (state == MAP_RD) map_q <= port_word[CCW-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_start) state_next = MAP_RD;
      MAP_RD:  state_next = MAP_DAT;
      MAP_DAT: state_next = ROM_REQ;
      ROM_REQ: if (rom_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Boundary loads replace the shift source so the tile's first pixel leaves on
  // the same enable that loads it.
  always_comb begin
    src_planes = shift_reg;
    src_color  = color_lat;
    if (boundary) begin
      src_planes = hold_valid ? hold_planes : '0;
      src_color  = hold_valid ? hold_color  : '0;
    end
    pix_bits = '0;
    shifted  = '0;
    for (int p = 0; p < PLANES; p++) begin
      if (SCREEN_FLIP) begin
        pix_bits[p]       = src_planes[8*p];
        shifted[8*p +: 8] = {1'b0, src_planes[8*p+1 +: 7]};
      end else begin
        pix_bits[p]       = src_planes[8*p+7];
        shifted[8*p +: 8] = {src_planes[8*p +: 7], 1'b0};
      end
    end
  end

  always_ff @(posedge master_clk) begin
    if (!RESET_N) begin
      state        <= IDLE;
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      fetch_cell   <= '0;
      fetch_row    <= '0;
      fetch_color  <= '0;
      hold_planes  <= '0;
      hold_color   <= '0;
      hold_valid   <= 1'b0;
      shift_reg    <= '0;
      color_lat    <= '0;
      pixel_out    <= '0;
      pixel_opaque <= 1'b0;
      underrun     <= 1'b0;
      cpu_dout     <= '0;
      cpu_active   <= 1'b0;
      cpu_done     <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      state   <= state_next;
      rom_req <= (state_next == ROM_REQ);

      if (fetch_start) begin
        fetch_cell <= {VPIXSCRL[VW-1:3], next_col};
        fetch_row  <= VPIXSCRL[2:0];
      end
      if (state == MAP_DAT) begin
        rom_addr    <= ROM_AW'({map_q[CODE_BITS-1:0], fetch_row});
        fetch_color <= map_q[CODE_BITS +: COLOR_BITS];
      end

      if (pixel_ce) begin
        shift_reg    <= shifted;
        color_lat    <= src_color;
        pixel_out    <= {src_color, pix_bits};
        pixel_opaque <= |pix_bits;
      end
      if (boundary) begin
        if (!hold_valid) underrun <= 1'b1;
        hold_valid <= 1'b0;
      end
      // Data arriving on a boundary cycle lands in holding for the next tile.
      if (rom_take) begin
        hold_planes <= rom_data;
        hold_color  <= fetch_color;
        hold_valid  <= 1'b1;
      end

      if (cpu_grant) begin
        cpu_active <= 1'b1;
        wait_cnt   <= '0;
        if (!cpu_we) cpu_dout <= cpu_addr[MAP_AW] ? port_word[15:8] : port_word[7:0];
      end else if (cpu_active) begin
        if (cpu_fin) begin
          cpu_active <= 1'b0;
          cpu_done   <= cpu_cs;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else if (!cpu_cs) begin
        cpu_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_layer_gen.sv
// tb/tb_tile_layer_gen.sv - directed self-checking bench for tile_layer_gen
module tb_tile_layer_gen;

  logic        master_clk = 1'b0;
  logic        RESET_N;
  logic        pixel_ce;
  logic [8:0]  HPIXSCRL;
  logic [7:0]  VPIXSCRL;
  logic        SCREEN_FLIP;
  logic        cpu_cs, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_wait;
  logic        rom_req, rom_ack;
  logic [16:0] rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  pixel_out;
  logic        pixel_opaque, underrun;

  int          checks = 0;
  int          failures = 0;
  logic        withhold;
  int          rom_cnt;
  logic [31:0] rom_word;
  logic [16:0] last_addr;
  logic [7:0]  rd;
  int          n;
  logic        w0;

  always #5 master_clk = ~master_clk;

  tile_layer_gen dut (
    .master_clk(master_clk), .RESET_N(RESET_N), .pixel_ce(pixel_ce),
    .HPIXSCRL(HPIXSCRL), .VPIXSCRL(VPIXSCRL), .SCREEN_FLIP(SCREEN_FLIP),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .pixel_out(pixel_out),
    .pixel_opaque(pixel_opaque), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards the graphics memory model answers a request two cycles in.
  task automatic tick();
    @(posedge master_clk);
    #1;
    if (rom_ack) rom_ack = 1'b0;
    else if (rom_req && !withhold) begin
      rom_cnt++;
      if (rom_cnt >= 2) begin
        rom_ack   = 1'b1;
        rom_data  = rom_word;
        last_addr = rom_addr;
        rom_cnt   = 0;
      end
    end else if (!rom_req) rom_cnt = 0;
  endtask

  task automatic pix(input logic [8:0] h);
    HPIXSCRL = h;
    pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    rom_ack = 1'b0;
    rom_cnt = 0;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] d,
                            output logic [7:0] q, output int cnt, output logic wait0);
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_cs = 1'b1;
    #1;
    wait0 = cpu_wait;
    cnt = 0;
    while (cpu_wait && cnt < 20) begin
      cnt++;
      tick();
    end
    q = cpu_dout;
    cpu_cs = 1'b0;
    tick();
  endtask

  // Tile 1 of a freshly reset frame: expected {5, plane0} then seven {5, 0} pixels.
  task automatic run_tile(input string tag);
    for (int h = 0; h < 8; h++) pix(9'(h));
    chk({tag, "_first"}, pixel_out, 32'h51);
    chk({tag, "_opaque"}, pixel_opaque, 1);
    chk({tag, "_rom_addr"}, last_addr, 32'h918);
    tick();
    chk({tag, "_hold_no_ce"}, pixel_out, 32'h51);
    for (int h = 8; h < 15; h++) begin
      pix(9'(h));
      chk($sformatf("%s_px%0d", tag, h), {pixel_opaque, pixel_out}, 32'h050);
    end
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  initial begin
    RESET_N = 1'b0; pixel_ce = 1'b0; HPIXSCRL = '0; VPIXSCRL = '0; SCREEN_FLIP = 1'b0;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    rom_ack = 1'b0; rom_data = '0; withhold = 1'b0; rom_cnt = 0; rom_word = '0; last_addr = '0;
    tick(); tick();
    RESET_N = 1'b1;
    chk("rst_rom_req", rom_req, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_opaque", pixel_opaque, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_cpu_dout", cpu_dout, 0);

    // Reset while a request is outstanding, then a stray ack.
    withhold = 1'b1;
    pix(0); pix(1); pix(2);
    chk("mid_fetch_req", rom_req, 1);
    do_reset();
    chk("abort_req", rom_req, 0);
    chk("abort_pixel", pixel_out, 0);
    chk("abort_underrun", underrun, 0);
    rom_data = '1;
    rom_ack  = 1'b1;
    tick();
    chk("late_ack_req", rom_req, 0);
    pix(9'd7);
    chk("late_ack_underrun", underrun, 1);
    chk("late_ack_pixel", pixel_out, 0);
    withhold = 1'b0;

    // Cell (0,1) = 0x5123
    cpu_access(1'b1, 12'h001, 8'h23, rd, n, w0);
    cpu_access(1'b1, 12'h801, 8'h51, rd, n, w0);

    do_reset();
    rom_word = 32'h0000_0080;
    run_tile("norm");

    do_reset();
    SCREEN_FLIP = 1'b1;
    rom_word = 32'h0000_0001;
    run_tile("flip");
    SCREEN_FLIP = 1'b0;

    // Graphics withheld past the boundary.
    do_reset();
    withhold = 1'b1;
    rom_word = 32'h0000_0080;
    for (int h = 0; h < 8; h++) pix(9'(h));
    chk("under_flag", underrun, 1);
    chk("under_first", pixel_out, 0);
    for (int h = 8; h < 15; h++) begin
      pix(9'(h));
      chk($sformatf("under_px%0d", h), {pixel_opaque, pixel_out}, 0);
    end
    withhold = 1'b0;
    for (int h = 15; h < 24; h++) pix(9'(h));
    chk("under_late_fill", pixel_out, 32'h51);
    chk("under_sticky", underrun, 1);

    // CPU write while the fetcher holds the map port.
    do_reset();
    pix(0);
    cpu_access(1'b1, 12'h805, 8'hAB, rd, n, w0);
    chk("wr_wait_immediate", w0, 1);
    chk("wr_wait_cycles", n, 4);
    cpu_access(1'b0, 12'h805, 8'h00, rd, n, w0);
    chk("rd_cell5_hi", rd, 32'hAB);
    chk("rd_wait_cycles", n, 3);
    chk("rd_dout_hold", cpu_dout, 32'hAB);
    cpu_access(1'b0, 12'h001, 8'h00, rd, n, w0);
    chk("rd_cell1_lo", rd, 32'h23);

    // Column wrap: last column fetches cell 0 (code 0xABC), pixel row 3.
    do_reset();
    withhold = 1'b1;
    VPIXSCRL = 8'h03;
    cpu_access(1'b1, 12'h000, 8'hBC, rd, n, w0);
    cpu_access(1'b1, 12'h800, 8'h0A, rd, n, w0);
    pix(9'h1F8);
    n = 0;
    while (!rom_req && n < 10) begin
      n++;
      tick();
    end
    chk("wrap_req", rom_req, 1);
    chk("wrap_addr", rom_addr, 32'h055E3);
    tick(); tick();
    chk("wrap_addr_stable", rom_addr, 32'h055E3);
    chk("wrap_req_held", rom_req, 1);
    withhold = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
